// File: rtl/spi_burst_ctrl.sv
// Byte-stream front end for spi_top: TX FIFO -> one SPI transfer per byte -> RX FIFO. Optional timeout via SPI_BURST_TIMEOUT_EN.
// Latency: byte written at E0 launches spi_start at E1; the RX byte appears one cycle after the CAPTURE edge.
// Backpressure: s_ready drops when the TX FIFO is full, and launches stall while the RX FIFO is full.

module spi_burst_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = (wptr == rptr);
    assign level    = wptr - rptr;
    assign head_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    // Storage carries no reset; the head is masked by empty.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

module spi_burst_ctrl #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic          spi_start,
    output logic [7:0]    spi_tx_data,
    input  logic [7:0]    spi_rx_data,
    input  logic          spi_ready,
    output logic          busy,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic          err,
    input  logic          err_clr
);
    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t     state;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic       launch_ok;
    logic       tx_pop;
    logic       rx_push;
    logic       timeout_hit;

    assign s_ready   = !tx_full;
    assign m_valid   = !rx_empty;
    // Gating on RX space means CAPTURE always has a free slot.
    assign launch_ok = !tx_empty && !rx_full && spi_ready;
    assign tx_pop    = (state == IDLE) && launch_ok;
    assign rx_push   = (state == CAPTURE);

    spi_burst_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s_valid),
        .push_dat (s_data),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level)
    );

    spi_burst_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (spi_rx_data),
        .pop      (m_ready),
        .head_dat (m_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level)
    );

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] to_cnt;
    logic          waiting;

    assign waiting     = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign timeout_hit = waiting && (to_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == LAUNCH)
                to_cnt <= '0;
            else if (waiting && !timeout_hit)
                to_cnt <= to_cnt + 1'b1;
            // A timeout in the same cycle as err_clr keeps the flag set.
            if (timeout_hit)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign unused_cfg  = err_clr ^ (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            spi_start   <= 1'b0;
            spi_tx_data <= 8'h00;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_ok) begin
                        state       <= LAUNCH;
                        spi_start   <= 1'b1;
                        spi_tx_data <= tx_head;
                        busy        <= 1'b1;
                    end
                end
                LAUNCH: begin
                    spi_start <= 1'b0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!spi_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (spi_ready) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    spi_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
